avalon_regfile_slave: RTL and testbench

AVALON_REGFILE_SLAVE -- requirements
Module: avalon_regfile_slave

---
 rtl/avalon_regfile_pkg.sv | 25 ++
 rtl/avalon_be_reg.sv | 40 ++++
 rtl/avalon_regfile_slave.sv | 133 +++++++++++++
 tb/tb_avalon_regfile_slave.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_regfile_pkg.sv
// Shared definitions for the Avalon-MM register file slave:
// default error pattern, index-width helper and FSM state encodings.
package avalon_regfile_pkg;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    // Number of bits needed to index 'value' entries (value >= 2).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/avalon_be_reg.sv
// Single register with per-byte-lane write enables; lanes whose byteenable
// bit is low keep their previous contents.
module avalon_be_reg #(
    parameter int WIDTH = 32
) (
    input  logic               iClk,
    input  logic               nReset,
    input  logic               enable,
    input  logic [WIDTH/8-1:0] byteenable,
    input  logic [WIDTH-1:0]   data,
    output logic [WIDTH-1:0]   q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        // NOTE: default assignment first so every path drives q_d (no latch).
        q_d = q_q;
        if (enable) begin
            for (int i = 0; i < WIDTH / 8; i++) begin
                if (byteenable[i]) begin
                    q_d[i*8 +: 8] = data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        // NOTE: reset is sampled on the clock edge (synchronous), and state uses <=.
        if (!nReset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/avalon_regfile_slave.sv
// Avalon-MM slave exposing NUM_REGS-1 byte-writable registers plus one
// read-only status word; every access takes exactly two clock cycles.
module avalon_regfile_slave
    import avalon_regfile_pkg::*;
#(
    parameter logic [31:0]           BASEADDRESS = 32'h0000_0000,
    parameter int                    ADDR_WIDTH  = 11,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA    = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
    input  logic                             iClk,
    input  logic                             nReset,
    input  logic [ADDR_WIDTH-1:0]            avs_pcp_address,
    input  logic [DATA_WIDTH/8-1:0]          avs_pcp_byteenable,
    input  logic                             avs_pcp_read,
    output logic [DATA_WIDTH-1:0]            avs_pcp_readdata,
    input  logic                             avs_pcp_write,
    input  logic [DATA_WIDTH-1:0]            avs_pcp_writedata,
    output logic                             avs_pcp_waitrequest,
    input  logic [DATA_WIDTH-1:0]            iStatus,
    output logic [(NUM_REGS-1)*DATA_WIDTH-1:0] oRegs,
    output logic [NUM_REGS-2:0]              oWrPulse
);

    localparam int               IDX_W      = clog2(NUM_REGS);
    localparam int               NUM_RW     = NUM_REGS - 1;
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W:0]   NUM_REGS_V = (IDX_W + 1)'(NUM_REGS);

    state_e                  state_q;
    state_e                  state_d;
    logic [DATA_WIDTH-1:0]   readdata_q;
    logic [DATA_WIDTH-1:0]   readdata_d;
    logic [NUM_RW-1:0]       wr_pulse_q;
    logic [NUM_RW-1:0]       wr_pulse_d;
    logic [NUM_RW-1:0]       reg_en;
    logic [DATA_WIDTH-1:0]   reg_q [NUM_RW];
    logic [DATA_WIDTH-1:0]   rd_value;

    logic                    req;
    logic [ADDR_WIDTH-3:0]   word_addr;
    logic [IDX_W-1:0]        idx;
    logic                    mapped;
    logic                    rw_hit;
    logic                    unused_bits;

    assign req       = avs_pcp_read | avs_pcp_write;
    assign word_addr = avs_pcp_address[ADDR_WIDTH-1:2];
    assign idx       = avs_pcp_address[IDX_W+1:2];

    // A word address is mapped only if it fits the index and stays below NUM_REGS;
    // higher words would otherwise alias onto low registers.
    assign mapped = ((word_addr >> IDX_W) == '0) && ({1'b0, idx} < NUM_REGS_V);
    assign rw_hit = mapped && (idx != STATUS_IDX);

    // Byte offset bits and the base address play no part in decode.
    assign unused_bits = &{1'b0, avs_pcp_address[1:0], BASEADDRESS[0]};

    always_comb begin
        rd_value = iStatus;
        for (int k = 0; k < NUM_RW; k++) begin
            if (idx == IDX_W'(k)) begin
                rd_value = reg_q[k];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        readdata_d = '0;
        wr_pulse_d = '0;
        reg_en     = '0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_ACK;
                    // A simultaneous read and write is served as a write only.
                    if (avs_pcp_write) begin
                        if (rw_hit) begin
                            for (int k = 0; k < NUM_RW; k++) begin
                                if (idx == IDX_W'(k)) begin
                                    reg_en[k]     = 1'b1;
                                    wr_pulse_d[k] = 1'b1;
                                end
                            end
                        end
                    end else begin
                        readdata_d = mapped ? rd_value : ERR_DATA;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!nReset) begin
            state_q    <= ST_IDLE;
            readdata_q <= '0;
            wr_pulse_q <= '0;
        end else begin
            state_q    <= state_d;
            readdata_q <= readdata_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    for (genvar k = 0; k < NUM_RW; k++) begin : g_reg
        avalon_be_reg #(
            .WIDTH(DATA_WIDTH)
        ) u_reg (
            .iClk      (iClk),
            .nReset    (nReset),
            .enable    (reg_en[k]),
            .byteenable(avs_pcp_byteenable),
            .data      (avs_pcp_writedata),
            .q         (reg_q[k])
        );
        assign oRegs[k*DATA_WIDTH +: DATA_WIDTH] = reg_q[k];
    end

    // Stall is held during reset so a pending request is never seen as accepted.
    assign avs_pcp_waitrequest = req & ((state_q != ST_ACK) | ~nReset);
    assign avs_pcp_readdata    = readdata_q;
    assign oWrPulse            = wr_pulse_q;

endmodule

// File: tb/tb_avalon_regfile_slave.sv
// Self-checking bench for avalon_regfile_slave: vector table with a scoreboard
// queue, plus back-to-back and reset-during-ACK sequences.
module tb_avalon_regfile_slave;

    localparam int AW       = 11;
    localparam int DW       = 32;
    localparam int NUM_REGS = 8;
    localparam int NRW      = NUM_REGS - 1;

    logic                iClk = 1'b0;
    logic                nReset;
    logic [AW-1:0]       avs_pcp_address;
    logic [DW/8-1:0]     avs_pcp_byteenable;
    logic                avs_pcp_read;
    logic [DW-1:0]       avs_pcp_readdata;
    logic                avs_pcp_write;
    logic [DW-1:0]       avs_pcp_writedata;
    logic                avs_pcp_waitrequest;
    logic [DW-1:0]       iStatus;
    logic [NRW*DW-1:0]   oRegs;
    logic [NRW-1:0]      oWrPulse;

    always #5 iClk = ~iClk;

    avalon_regfile_slave #(
        .BASEADDRESS(32'h0000_0000),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NUM_REGS),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .iClk               (iClk),
        .nReset             (nReset),
        .avs_pcp_address    (avs_pcp_address),
        .avs_pcp_byteenable (avs_pcp_byteenable),
        .avs_pcp_read       (avs_pcp_read),
        .avs_pcp_readdata   (avs_pcp_readdata),
        .avs_pcp_write      (avs_pcp_write),
        .avs_pcp_writedata  (avs_pcp_writedata),
        .avs_pcp_waitrequest(avs_pcp_waitrequest),
        .iStatus            (iStatus),
        .oRegs              (oRegs),
        .oWrPulse           (oWrPulse)
    );

    typedef struct {
        logic           wr;
        logic           rd;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [3:0]     be;
        logic [DW-1:0]  status;
        logic [DW-1:0]  exp_rdata;
        logic [NRW-1:0] exp_pulse;
    } vec_t;

    typedef struct {
        logic [DW-1:0]  rdata;
        logic [NRW-1:0] pulse;
    } exp_t;

    vec_t           vecs [15];
    exp_t           exp_q [$];
    logic [DW-1:0]  model [NRW];
    int             n_tests = 0;
    int             n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NRW*DW-1:0] model_flat();
        logic [NRW*DW-1:0] r;
        for (int k = 0; k < NRW; k++) r[k*DW +: DW] = model[k];
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NRW; k++) model[k] = '0;
    endtask

    // Called just after a rising edge; returns just after the edge ending ACK.
    task automatic access(input logic wr, input logic rd, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [3:0] be,
                          input logic [DW-1:0] status, input logic [DW-1:0] exp_rdata,
                          input logic [NRW-1:0] exp_pulse, input string tag);
        exp_t e;
        int   stalls;
        bit   done;
        int   w;
        avs_pcp_write      = wr;
        avs_pcp_read       = rd;
        avs_pcp_address    = addr;
        avs_pcp_writedata  = data;
        avs_pcp_byteenable = be;
        iStatus            = status;
        e.rdata = exp_rdata;
        e.pulse = exp_pulse;
        exp_q.push_back(e);
        w = int'(addr[AW-1:2]);
        if (wr && w < NRW) begin
            for (int i = 0; i < DW / 8; i++) begin
                if (be[i]) model[w][i*8 +: 8] = data[i*8 +: 8];
            end
        end
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge iClk);
            if (avs_pcp_waitrequest) begin
                stalls++;
                @(posedge iClk);
                #1;
            end else begin
                done = 1'b1;
            end
        end
        check({tag, " ack seen"}, 256'(done), 256'(1));
        if (done) begin
            check({tag, " stall cycles"}, 256'(stalls), 256'(1));
            e = exp_q.pop_front();
            check({tag, " readdata"}, 256'(avs_pcp_readdata), 256'(e.rdata));
            check({tag, " wrpulse"}, 256'(oWrPulse), 256'(e.pulse));
            check({tag, " regs"}, 256'(oRegs), 256'(model_flat()));
        end else begin
            exp_q.delete();
        end
        @(posedge iClk);
        #1;
    endtask

    task automatic idle(input string tag);
        avs_pcp_read  = 1'b0;
        avs_pcp_write = 1'b0;
        @(negedge iClk);
        check({tag, " idle readdata"}, 256'(avs_pcp_readdata), 256'(0));
        check({tag, " idle wrpulse"}, 256'(oWrPulse), 256'(0));
        check({tag, " idle waitreq"}, 256'(avs_pcp_waitrequest), 256'(0));
        check({tag, " idle regs"}, 256'(oRegs), 256'(model_flat()));
        @(posedge iClk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        //                wr    rd    addr     data          be    status        exp_rdata     exp_pulse
        vecs[0]  = '{1'b1, 1'b0, 11'h004, 32'h1234_5678, 4'hF, 32'h5A5A_0000, 32'h0000_0000, 7'h02};
        vecs[1]  = '{1'b1, 1'b0, 11'h004, 32'hAABB_CCDD, 4'h5, 32'h5A5A_0000, 32'h0000_0000, 7'h02};
        vecs[2]  = '{1'b0, 1'b1, 11'h004, 32'h0000_0000, 4'hF, 32'h5A5A_0000, 32'h12BB_56DD, 7'h00};
        vecs[3]  = '{1'b0, 1'b1, 11'h01C, 32'h0000_0000, 4'hF, 32'hCAFE_0001, 32'hCAFE_0001, 7'h00};
        vecs[4]  = '{1'b1, 1'b0, 11'h01C, 32'hFFFF_FFFF, 4'hF, 32'hCAFE_0001, 32'h0000_0000, 7'h00};
        vecs[5]  = '{1'b0, 1'b1, 11'h040, 32'h0000_0000, 4'hF, 32'h5A5A_0000, 32'hDEAD_BEEF, 7'h00};
        vecs[6]  = '{1'b1, 1'b0, 11'h040, 32'h1111_1111, 4'hF, 32'h5A5A_0000, 32'h0000_0000, 7'h00};
        vecs[7]  = '{1'b1, 1'b0, 11'h020, 32'h2222_2222, 4'hF, 32'h5A5A_0000, 32'h0000_0000, 7'h00};
        vecs[8]  = '{1'b0, 1'b1, 11'h020, 32'h0000_0000, 4'hF, 32'h5A5A_0000, 32'hDEAD_BEEF, 7'h00};
        vecs[9]  = '{1'b1, 1'b0, 11'h008, 32'h0000_00A5, 4'h1, 32'h5A5A_0000, 32'h0000_0000, 7'h04};
        vecs[10] = '{1'b0, 1'b1, 11'h00B, 32'h0000_0000, 4'h0, 32'h5A5A_0000, 32'h0000_00A5, 7'h00};
        vecs[11] = '{1'b1, 1'b1, 11'h018, 32'h6666_6666, 4'hF, 32'h5A5A_0000, 32'h0000_0000, 7'h40};
        vecs[12] = '{1'b0, 1'b1, 11'h018, 32'h0000_0000, 4'hF, 32'h5A5A_0000, 32'h6666_6666, 7'h00};
        vecs[13] = '{1'b1, 1'b0, 11'h000, 32'hFFFF_FFFF, 4'h0, 32'h5A5A_0000, 32'h0000_0000, 7'h01};
        vecs[14] = '{1'b0, 1'b1, 11'h7FC, 32'h0000_0000, 4'hF, 32'h5A5A_0000, 32'hDEAD_BEEF, 7'h00};

        model_clear();
        nReset             = 1'b0;
        avs_pcp_read       = 1'b0;
        avs_pcp_write      = 1'b1;
        avs_pcp_address    = 11'h004;
        avs_pcp_writedata  = 32'hFFFF_FFFF;
        avs_pcp_byteenable = 4'hF;
        iStatus            = 32'h0;

        // Reset with a request pending: stalled, nothing committed.
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        check("reset waitreq", 256'(avs_pcp_waitrequest), 256'(1));
        check("reset readdata", 256'(avs_pcp_readdata), 256'(0));
        check("reset wrpulse", 256'(oWrPulse), 256'(0));
        check("reset regs", 256'(oRegs), 256'(0));
        @(posedge iClk);
        #1;
        avs_pcp_write = 1'b0;
        nReset        = 1'b1;
        idle("post-reset");

        for (int i = 0; i < 15; i++) begin
            access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].be,
                   vecs[i].status, vecs[i].exp_rdata, vecs[i].exp_pulse, $sformatf("vec%0d", i));
            idle($sformatf("vec%0d", i));
        end
        check("reg1 byte-merged", 256'(oRegs[1*DW +: DW]), 256'(32'h12BB_56DD));
        check("reg0 be=0 write", 256'(oRegs[0 +: DW]), 256'(0));

        // Back-to-back write then read of reg2, request held continuously.
        access(1'b1, 1'b0, 11'h008, 32'hFEED_0002, 4'hF, 32'h0, 32'h0, 7'h04, "b2b write");
        access(1'b0, 1'b1, 11'h008, 32'h0, 4'hF, 32'h0, 32'hFEED_0002, 7'h00, "b2b read");
        idle("b2b");

        // Reset asserted during the ACK cycle of a write to reg3.
        avs_pcp_write      = 1'b1;
        avs_pcp_read       = 1'b0;
        avs_pcp_address    = 11'h00C;
        avs_pcp_writedata  = 32'h3333_3333;
        avs_pcp_byteenable = 4'hF;
        @(negedge iClk);
        check("rst-ack stall", 256'(avs_pcp_waitrequest), 256'(1));
        @(posedge iClk);
        #1;
        @(negedge iClk);
        check("rst-ack pulse in ack", 256'(oWrPulse), 256'(7'h08));
        check("rst-ack reg3 in ack", 256'(oRegs[3*DW +: DW]), 256'(32'h3333_3333));
        nReset = 1'b0;
        @(posedge iClk);
        #1;
        model_clear();
        check("rst-ack wrpulse", 256'(oWrPulse), 256'(0));
        check("rst-ack readdata", 256'(avs_pcp_readdata), 256'(0));
        check("rst-ack regs", 256'(oRegs), 256'(0));
        check("rst-ack waitreq held", 256'(avs_pcp_waitrequest), 256'(1));
        avs_pcp_write = 1'b0;
        nReset        = 1'b1;
        access(1'b0, 1'b1, 11'h00C, 32'h0, 4'hF, 32'h0, 32'h0, 7'h00, "post-rst read reg3");
        idle("post-rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
